clint_mh: RTL and testbench

Parametrised multi-hart core-local interruptor in the CLINT window at 0x0200_0000. It holds one 64-bit mtime counter with a programmable tick prescaler, plus one MSIP bit and one 64-bit mtimecmp per hart. It drives per-hart software and timer interrupt lines to the harts. The LSU reaches it through a single-cycle request/response memory-mapped register port.

---
 rtl/clint_mh.sv | 169 ++++++++++++++++
 tb/tb_clint_mh.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: prescaled 64-bit mtime, per-hart MSIP and
// MTIMECMP, and a single-cycle memory-mapped register port.
module clint_mh #(
    parameter int          XLEN      = 32,
    parameter int          NUM_HARTS = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          TICK_DIV  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mtime_en,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    input  logic [3:0]           req_wstrb,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_rdata,
    output logic                 resp_err,
    output logic [NUM_HARTS-1:0] msip_o,
    output logic [NUM_HARTS-1:0] mtip_o
);

    localparam int               DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [31:0]      NH_U    = 32'(NUM_HARTS);

    typedef enum logic [2:0] {
        REG_NONE = 3'd0,
        REG_MSIP = 3'd1,
        REG_CMP  = 3'd2,
        REG_MTL  = 3'd3,
        REG_MTH  = 3'd4
    } region_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    logic [63:0]          mtime_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic [63:0]          mtimecmp_r [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip_r;
    logic [NUM_HARTS-1:0] mtip_r;
    logic                 resp_valid_r;
    logic [31:0]          resp_rdata_r;
    logic                 resp_err_r;

    logic [15:0]          offset_s;
    logic [31:0]          msip_idx_s;
    logic [31:0]          cmp_idx_s;
    region_e              region_s;
    logic [NUM_HARTS-1:0] msip_sel_s;
    logic [NUM_HARTS-1:0] cmp_sel_s;
    logic                 err_s;
    logic                 wr_s;
    logic                 tick_s;
    logic [31:0]          rdata_s;
    logic [63:0]          mtime_base_s;
    logic [63:0]          mtime_nxt_s;

    // Address decode: region and per-hart selects.
    always_comb begin
        offset_s   = req_addr[15:0];
        msip_idx_s = {20'd0, offset_s[13:2]};
        cmp_idx_s  = {21'd0, offset_s[13:3]};
        if ((req_addr[31:16] != BASE_ADDR[31:16]) || (req_addr[1:0] != 2'b00)) begin
            region_s = REG_NONE;
        end else if ((offset_s[15:14] == 2'b00) && (msip_idx_s < NH_U)) begin
            region_s = REG_MSIP;
        end else if ((offset_s[15:14] == 2'b01) && (cmp_idx_s < NH_U)) begin
            region_s = REG_CMP;
        end else if (offset_s == 16'hBFF8) begin
            region_s = REG_MTL;
        end else if (offset_s == 16'hBFFC) begin
            region_s = REG_MTH;
        end else begin
            region_s = REG_NONE;
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            msip_sel_s[h] = (msip_idx_s == 32'(h));
            cmp_sel_s[h]  = (cmp_idx_s == 32'(h));
        end
        err_s = (region_s == REG_NONE);
        wr_s  = req_valid && req_we && !err_s;
    end

    // Read mux over the pre-edge register values.
    always_comb begin
        rdata_s = 32'd0;
        case (region_s)
            REG_MSIP: rdata_s = {31'd0, |(msip_r & msip_sel_s)};
            REG_CMP: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    rdata_s = rdata_s | (cmp_sel_s[h] ?
                              (offset_s[2] ? mtimecmp_r[h][63:32] : mtimecmp_r[h][31:0]) : 32'd0);
                end
            end
            REG_MTL:  rdata_s = mtime_r[31:0];
            REG_MTH:  rdata_s = mtime_r[63:32];
            default:  rdata_s = 32'd0;
        endcase
    end

    // Next mtime: tick increment first, then written bytes override it.
    always_comb begin
        tick_s       = mtime_en && (div_cnt_r == DIV_MAX);
        mtime_base_s = tick_s ? (mtime_r + 64'd1) : mtime_r;
        mtime_nxt_s  = mtime_base_s;
        if (wr_s && (region_s == REG_MTL)) begin
            mtime_nxt_s[31:0] = byte_merge(mtime_base_s[31:0], req_wdata, req_wstrb);
        end else if (wr_s && (region_s == REG_MTH)) begin
            mtime_nxt_s[63:32] = byte_merge(mtime_base_s[63:32], req_wdata, req_wstrb);
        end else begin
            mtime_nxt_s = mtime_base_s;
        end
    end

    // Timer, per-hart registers and bus response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_r      <= 64'd0;
            div_cnt_r    <= '0;
            msip_r       <= '0;
            mtip_r       <= '0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtimecmp_r[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else begin
            if (mtime_en) begin
                div_cnt_r <= tick_s ? '0 : div_cnt_r + DIV_W'(1);
            end
            mtime_r <= mtime_nxt_s;
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (wr_s && (region_s == REG_MSIP) && msip_sel_s[h] && req_wstrb[0]) begin
                    msip_r[h] <= req_wdata[0];
                end
                if (wr_s && (region_s == REG_CMP) && cmp_sel_s[h]) begin
                    if (offset_s[2]) begin
                        mtimecmp_r[h][63:32] <= byte_merge(mtimecmp_r[h][63:32], req_wdata, req_wstrb);
                    end else begin
                        mtimecmp_r[h][31:0] <= byte_merge(mtimecmp_r[h][31:0], req_wdata, req_wstrb);
                    end
                end
                // Compare uses last cycle's registers, giving the 2-cycle mtip latency.
                mtip_r[h] <= (mtime_r >= mtimecmp_r[h]);
            end
            resp_valid_r <= req_valid;
            resp_err_r   <= req_valid && err_s;
            resp_rdata_r <= (req_valid && !req_we && !err_s) ? rdata_s : 32'd0;
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign msip_o     = msip_r;
    assign mtip_o     = mtip_r;

endmodule

// File: tb/tb_clint_mh.sv
// Self-checking bench for clint_mh: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the register map.
module tb_clint_mh;

    localparam int          NH   = 2;
    localparam int          TD   = 4;
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mtime_en = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic [3:0]    req_wstrb = 4'd0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [NH-1:0] msip_o;
    logic [NH-1:0] mtip_o;

    clint_mh #(.XLEN(32), .NUM_HARTS(NH), .BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .mtime_en(mtime_en),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .msip_o(msip_o), .mtip_o(mtip_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // reference model state
    logic [63:0]   m_time;
    int            m_div;
    logic [63:0]   m_cmp [NH];
    logic [NH-1:0] m_msip;
    logic          e_valid;
    logic [31:0]   e_rdata;
    logic          e_err;
    logic [NH-1:0] e_mtip;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mix_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // One clock: drive a request, advance the model, compare all outputs after the edge.
    task automatic step(input logic v, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
        int          kind;
        int          h;
        logic        hi;
        logic [31:0] off;
        logic [31:0] rv;
        logic [63:0] nt;
        logic [NH-1:0] cmp_now;
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
        kind = 0; h = 0; hi = 1'b0; rv = 32'd0;
        off = a - BASE;
        if (a >= BASE && a < BASE + 32'h1_0000 && (a % 4) == 0) begin
            if (off < 4 * NH) begin
                kind = 1; h = off / 4;
            end else if (off >= 32'h4000 && off < 32'h4000 + 8 * NH) begin
                kind = 2; h = (off - 32'h4000) / 8; hi = ((off % 8) != 0);
            end else if (off == 32'hBFF8) begin
                kind = 3;
            end else if (off == 32'hBFFC) begin
                kind = 4;
            end
        end
        case (kind)
            1: rv = {31'd0, m_msip[h]};
            2: rv = hi ? m_cmp[h][63:32] : m_cmp[h][31:0];
            3: rv = m_time[31:0];
            4: rv = m_time[63:32];
            default: rv = 32'd0;
        endcase
        for (int i = 0; i < NH; i++) cmp_now[i] = (m_time >= m_cmp[i]);
        if (!rst_n) begin
            m_time = 64'd0; m_div = 0; m_msip = '0;
            for (int i = 0; i < NH; i++) m_cmp[i] = '1;
            e_valid = 1'b0; e_rdata = 32'd0; e_err = 1'b0; e_mtip = '0;
        end else begin
            e_valid = v;
            e_err   = v && (kind == 0);
            e_rdata = (v && !we && kind != 0) ? rv : 32'd0;
            e_mtip  = cmp_now;
            nt = m_time;
            if (mtime_en) begin
                if (m_div == TD - 1) begin
                    m_div = 0; nt = m_time + 64'd1;
                end else begin
                    m_div = m_div + 1;
                end
            end
            if (v && we) begin
                case (kind)
                    1: if (ws[0]) m_msip[h] = wd[0];
                    2: if (hi) m_cmp[h][63:32] = mix_bytes(m_cmp[h][63:32], wd, ws);
                       else    m_cmp[h][31:0]  = mix_bytes(m_cmp[h][31:0], wd, ws);
                    3: nt[31:0]  = mix_bytes(nt[31:0], wd, ws);
                    4: nt[63:32] = mix_bytes(nt[63:32], wd, ws);
                    default: ;
                endcase
            end
            m_time = nt;
        end
        @(posedge clk);
        #1;
        check_val("resp_valid", resp_valid, e_valid);
        check_val("resp_rdata", resp_rdata, e_rdata);
        check_val("resp_err", resp_err, e_err);
        check_val("msip_o", msip_o, m_msip);
        check_val("mtip_o", mtip_o, e_mtip);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        step(1'b1, 1'b1, a, d, s);
    endtask

    initial begin
        logic [31:0] addrs [14];
        logic [31:0] a;
        logic [31:0] d;
        logic [63:0] snap;
        addrs = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'h4000, BASE + 32'h4004,
                  BASE + 32'h4008, BASE + 32'h400C, BASE + 32'h4010, BASE + 32'hBFF8,
                  BASE + 32'hBFFC, BASE + 32'h4002, BASE + 32'h1_0000, BASE - 32'h4,
                  BASE + 32'h1000};

        // reset held 3 cycles, including a request that must be dropped
        rst_n = 1'b0;
        idle(1);
        rd(BASE + 32'hBFF8);
        idle(1);
        rst_n = 1'b1;
        idle(39);
        rd(BASE + 32'hBFF8);
        check_val("mtime_lo_at_40", resp_rdata, 64'd9);
        rd(BASE + 32'h400C);
        check_val("cmp1_hi_reset", resp_rdata, 64'hFFFF_FFFF);

        // timer interrupt on hart 0
        wr(BASE + 32'h4004, 32'd0, 4'hF);
        wr(BASE + 32'h4000, 32'd20, 4'hF);
        idle(60);
        check_val("mtip_set", mtip_o, 64'd1);
        wr(BASE + 32'h4004, 32'd1, 4'hF);
        idle(3);
        check_val("mtip_clear", mtip_o, 64'd0);

        // software interrupt on hart 1
        wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'hF);
        check_val("msip_set", msip_o, 64'd2);
        rd(BASE + 32'h4);
        check_val("msip1_read", resp_rdata, 64'd1);
        wr(BASE + 32'h4, 32'd0, 4'b0000);
        idle(1);
        check_val("msip_hold", msip_o, 64'd2);

        // carry out of the low word, then a partial write in a tick cycle
        wr(BASE + 32'hBFF8, 32'hFFFF_FFFE, 4'hF);
        wr(BASE + 32'hBFFC, 32'd0, 4'hF);
        idle(12);
        rd(BASE + 32'hBFFC);
        check_val("mtime_carry", resp_rdata, 64'd1);
        for (int i = 0; i < TD && m_div != TD - 1; i++) idle(1);
        wr(BASE + 32'hBFF8, 32'h0000_00AA, 4'b0001);
        rd(BASE + 32'hBFF8);

        // error accesses
        rd(BASE + 32'h8);
        check_val("err_msip2", {resp_err, resp_rdata}, {1'b1, 32'd0});
        wr(BASE + 32'h4002, 32'h1234_5678, 4'hF);
        check_val("err_misalign", resp_err, 64'd1);
        rd(BASE + 32'h1_0000);
        check_val("err_window", resp_err, 64'd1);
        rd(BASE + 32'h4000);
        rd(BASE + 32'h4004);

        // freeze time
        mtime_en = 1'b0;
        snap = m_time;
        idle(50);
        rd(BASE + 32'hBFF8);
        check_val("freeze_lo", resp_rdata, {32'd0, snap[31:0]});
        mtime_en = 1'b1;

        // reset in the middle of a read burst
        rd(BASE + 32'hBFF8);
        rst_n = 1'b0;
        rd(BASE + 32'hBFF8);
        rst_n = 1'b1;
        rd(BASE + 32'hBFF8);
        check_val("mtime_after_rst", resp_rdata, 64'd0);
        rd(BASE + 32'hBFFC);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            mtime_en = ($urandom_range(0, 9) != 0);
            a = addrs[$urandom_range(0, 13)];
            case ($urandom_range(0, 2))
                0: d = $urandom;
                1: d = m_time[31:0] + $urandom_range(0, 20);
                default: d = m_time[63:32];
            endcase
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, d, 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
